// File: rtl/mc_control_fsm.sv
// Moore control unit for the multicycle MIPS-subset datapath.
// It sequences fetch, decode, execute, memory and writeback for R-type, lw, sw,
// beq, bne, j and addi, and drives every datapath select and write strobe.
// The outputs are registered. They are computed from the state being entered,
// so each output bit always matches state_out in the same cycle.

module mc_control_fsm #(
   parameter int MEM_WAIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [1:0] ula_a_sel,
   output logic [1:0] ula_b_sel,
   output logic [2:0] alu_op,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       branch_ne,
   output logic [1:0] pc_source,
   output logic       iord,
   output logic       mem_wr,
   output logic       ir_write,
   output logic       mdr_write,
   output logic       ab_write,
   output logic       aluout_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       illegal,
   output logic [3:0] state_out
);

   typedef enum logic [3:0] {
      S_RESET     = 4'd0,
      S_FETCH     = 4'd1,
      S_FETCH_IR  = 4'd2,
      S_DECODE    = 4'd3,
      S_MEM_ADDR  = 4'd4,
      S_MEM_RD    = 4'd5,
      S_LOAD_MDR  = 4'd6,
      S_LOAD_WB   = 4'd7,
      S_MEM_WR    = 4'd8,
      S_R_EXEC    = 4'd9,
      S_R_WB      = 4'd10,
      S_ADDI_EXEC = 4'd11,
      S_ADDI_WB   = 4'd12,
      S_BRANCH    = 4'd13,
      S_JUMP      = 4'd14,
      S_EXCEPT    = 4'd15
   } state_t;

   typedef struct packed {
      logic [1:0] ula_a_sel;
      logic [1:0] ula_b_sel;
      logic [2:0] alu_op;
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic [1:0] pc_source;
      logic       iord;
      logic       mem_wr;
      logic       ir_write;
      logic       mdr_write;
      logic       ab_write;
      logic       aluout_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       illegal;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // The wait counter is reloaded with this value each time a memory-read state is entered.
   localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT);

   state_t     state;
   state_t     next_state;
   logic [2:0] wait_cnt;
   logic [2:0] next_cnt;
   logic [5:0] funct_q;
   logic [5:0] next_funct;
   ctrl_t      ctrl;

   // ALU operation for the supported R-type functs. An undefined funct gives 000.
   function automatic logic [2:0] funct_alu_op(input logic [5:0] f);
      case (f)
         6'h20:   return 3'b001;
         6'h22:   return 3'b010;
         6'h24:   return 3'b011;
         6'h25:   return 3'b100;
         6'h2A:   return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic funct_legal(input logic [5:0] f);
      return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h25) || (f == 6'h2A);
   endfunction

   // Moore output table. The only data-dependent outputs are alu_op and
   // aluout_write in R_EXEC (from the latched funct) and branch_ne in BRANCH.
   function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] f, input logic ne);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: c.iord = 1'b0;
         S_FETCH_IR: begin
            c.ir_write  = 1'b1;
            c.ula_b_sel = 2'b01;
            c.alu_op    = 3'b001;
            c.pc_write  = 1'b1;
         end
         S_DECODE: begin
            c.ab_write     = 1'b1;
            c.ula_b_sel    = 2'b11;
            c.alu_op       = 3'b001;
            c.aluout_write = 1'b1;
         end
         S_MEM_ADDR, S_ADDI_EXEC: begin
            c.ula_a_sel    = 2'b10;
            c.ula_b_sel    = 2'b10;
            c.alu_op       = 3'b001;
            c.aluout_write = 1'b1;
         end
         S_MEM_RD: c.iord = 1'b1;
         S_LOAD_MDR: begin
            c.iord      = 1'b1;
            c.mdr_write = 1'b1;
         end
         S_LOAD_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            c.iord   = 1'b1;
            c.mem_wr = 1'b1;
         end
         S_R_EXEC: begin
            c.ula_a_sel    = 2'b10;
            c.alu_op       = funct_alu_op(f);
            c.aluout_write = funct_legal(f);
         end
         S_R_WB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         S_ADDI_WB: c.reg_write = 1'b1;
         S_BRANCH: begin
            c.ula_a_sel     = 2'b10;
            c.alu_op        = 3'b010;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
            c.branch_ne     = ne;
         end
         S_JUMP: begin
            c.pc_source = 2'b10;
            c.pc_write  = 1'b1;
         end
         S_EXCEPT: c.illegal = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

   // Next-state, wait-counter and funct-latch logic.
   always_comb begin
      next_state = state;
      next_cnt   = wait_cnt;
      next_funct = funct_q;
      case (state)
         S_RESET: begin
            next_state = S_FETCH;
            next_cnt   = WAIT_LOAD;
         end
         S_FETCH: begin
            if (wait_cnt == 3'd0) next_state = S_FETCH_IR;
            else                  next_cnt   = wait_cnt - 3'd1;
         end
         S_FETCH_IR: next_state = S_DECODE;
         S_DECODE: begin
            next_funct = funct;
            case (opcode)
               OP_RTYPE:      next_state = S_R_EXEC;
               OP_LW, OP_SW:  next_state = S_MEM_ADDR;
               OP_BEQ, OP_BNE: next_state = S_BRANCH;
               OP_J:          next_state = S_JUMP;
               OP_ADDI:       next_state = S_ADDI_EXEC;
               default:       next_state = S_EXCEPT;
            endcase
         end
         S_MEM_ADDR: begin
            if (opcode == OP_LW) begin
               next_state = S_MEM_RD;
               next_cnt   = WAIT_LOAD;
            end else begin
               next_state = S_MEM_WR;
            end
         end
         S_MEM_RD: begin
            if (wait_cnt == 3'd0) next_state = S_LOAD_MDR;
            else                  next_cnt   = wait_cnt - 3'd1;
         end
         S_LOAD_MDR:  next_state = S_LOAD_WB;
         S_R_EXEC:    next_state = funct_legal(funct_q) ? S_R_WB : S_EXCEPT;
         S_ADDI_EXEC: next_state = S_ADDI_WB;
         default: begin
            next_state = S_FETCH;
            next_cnt   = WAIT_LOAD;
         end
      endcase
   end

   // State, counter, funct latch and registered Moore outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_RESET;
         wait_cnt <= 3'd0;
         funct_q  <= 6'd0;
         ctrl     <= '0;
      end else begin
         state    <= next_state;
         wait_cnt <= next_cnt;
         funct_q  <= next_funct;
         ctrl     <= decode_ctrl(next_state, next_funct, opcode[0]);
      end
   end

   assign ula_a_sel     = ctrl.ula_a_sel;
   assign ula_b_sel     = ctrl.ula_b_sel;
   assign alu_op        = ctrl.alu_op;
   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign branch_ne     = ctrl.branch_ne;
   assign pc_source     = ctrl.pc_source;
   assign iord          = ctrl.iord;
   assign mem_wr        = ctrl.mem_wr;
   assign ir_write      = ctrl.ir_write;
   assign mdr_write     = ctrl.mdr_write;
   assign ab_write      = ctrl.ab_write;
   assign aluout_write  = ctrl.aluout_write;
   assign reg_write     = ctrl.reg_write;
   assign reg_dst       = ctrl.reg_dst;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign illegal       = ctrl.illegal;
   assign state_out     = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Testbench for mc_control_fsm. Two instances run side by side, one with
// MEM_WAIT=1 and one with MEM_WAIT=3. For every instruction, a reference model
// builds the expected cycle-by-cycle trace from the instruction's phase list and
// queues it. A monitor then compares each queued entry with the outputs at the
// falling edge. The monitor also checks the output invariants in every cycle.

module tb_mc_control_fsm;

   localparam int MW0 = 1;
   localparam int MW1 = 3;

   typedef struct packed {
      logic [3:0] st;
      logic [1:0] a_sel;
      logic [1:0] b_sel;
      logic [2:0] op;
      logic       pcw;
      logic       pcwc;
      logic       bne;
      logic [1:0] psrc;
      logic       iord;
      logic       memwr;
      logic       irw;
      logic       mdrw;
      logic       abw;
      logic       aow;
      logic       rw;
      logic       rdst;
      logic       m2r;
      logic       ill;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst [2];
   logic [5:0] opc [2];
   logic [5:0] fn  [2];
   vec_t       obs [2];

   vec_t expq0[$];
   vec_t expq1[$];
   int   compared = 0;
   int   failed   = 0;

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [1:0] ula_a_sel, ula_b_sel, pc_source;
      logic [2:0] alu_op;
      logic [3:0] state_out;
      logic pc_write, pc_write_cond, branch_ne, iord, mem_wr, ir_write, mdr_write;
      logic ab_write, aluout_write, reg_write, reg_dst, mem_to_reg, illegal;

      mc_control_fsm #(.MEM_WAIT(g == 0 ? MW0 : MW1)) dut (
         .clk(clk), .reset(rst[g]), .opcode(opc[g]), .funct(fn[g]),
         .ula_a_sel(ula_a_sel), .ula_b_sel(ula_b_sel), .alu_op(alu_op),
         .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
         .pc_source(pc_source), .iord(iord), .mem_wr(mem_wr), .ir_write(ir_write),
         .mdr_write(mdr_write), .ab_write(ab_write), .aluout_write(aluout_write),
         .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
         .illegal(illegal), .state_out(state_out));

      assign obs[g] = {state_out, ula_a_sel, ula_b_sel, alu_op, pc_write, pc_write_cond,
                       branch_ne, pc_source, iord, mem_wr, ir_write, mdr_write, ab_write,
                       aluout_write, reg_write, reg_dst, mem_to_reg, illegal};
   end

   function automatic vec_t blank(input logic [3:0] st);
      vec_t v;
      v = '0;
      v.st = st;
      return v;
   endfunction

   // Returns the ALU code for a defined R-type funct, or -1 for an undefined one.
   function automatic int r_alu(input logic [5:0] f);
      case (f)
         6'h20:   return 1;
         6'h22:   return 2;
         6'h24:   return 3;
         6'h25:   return 4;
         6'h2A:   return 7;
         default: return -1;
      endcase
   endfunction

   task automatic push_exp(input int d, input vec_t v);
      if (d == 0) expq0.push_back(v);
      else        expq1.push_back(v);
   endtask

   // Holds reset for n cycles. Every one of those cycles is expected to show RESET with all outputs low.
   task automatic reset_dut(input int d, input int n);
      rst[d] = 1'b1;
      for (int i = 0; i < n; i++) push_exp(d, blank(4'd0));
      repeat (n) @(posedge clk);
      #1;
      rst[d] = 1'b0;
   endtask

   // Runs one instruction from FETCH entry. The expected trace is queued first.
   // When cut > 0, only the first cut cycles are run, so the caller can abort with reset.
   task automatic apply_stimulus(input int d, input logic [5:0] op, input logic [5:0] f, input int cut);
      vec_t tr[$];
      vec_t v;
      int   mw;
      int   n;
      int   alu;
      mw = (d == 0) ? MW0 : MW1;
      opc[d] = op;
      fn[d]  = f;
      v = blank(4'd1);
      for (int i = 0; i <= mw; i++) tr.push_back(v);
      v = blank(4'd2); v.irw = 1'b1; v.b_sel = 2'b01; v.op = 3'b001; v.pcw = 1'b1;
      tr.push_back(v);
      v = blank(4'd3); v.abw = 1'b1; v.b_sel = 2'b11; v.op = 3'b001; v.aow = 1'b1;
      tr.push_back(v);
      case (op)
         6'h00: begin
            alu = r_alu(f);
            v = blank(4'd9); v.a_sel = 2'b10;
            if (alu >= 0) begin
               v.op = 3'(alu); v.aow = 1'b1;
               tr.push_back(v);
               v = blank(4'd10); v.rw = 1'b1; v.rdst = 1'b1;
               tr.push_back(v);
            end else begin
               tr.push_back(v);
               v = blank(4'd15); v.ill = 1'b1;
               tr.push_back(v);
            end
         end
         6'h23, 6'h2B: begin
            v = blank(4'd4); v.a_sel = 2'b10; v.b_sel = 2'b10; v.op = 3'b001; v.aow = 1'b1;
            tr.push_back(v);
            if (op == 6'h23) begin
               v = blank(4'd5); v.iord = 1'b1;
               for (int i = 0; i <= mw; i++) tr.push_back(v);
               v = blank(4'd6); v.iord = 1'b1; v.mdrw = 1'b1;
               tr.push_back(v);
               v = blank(4'd7); v.rw = 1'b1; v.m2r = 1'b1;
               tr.push_back(v);
            end else begin
               v = blank(4'd8); v.iord = 1'b1; v.memwr = 1'b1;
               tr.push_back(v);
            end
         end
         6'h04, 6'h05: begin
            v = blank(4'd13); v.a_sel = 2'b10; v.op = 3'b010; v.pcwc = 1'b1;
            v.psrc = 2'b01; v.bne = op[0];
            tr.push_back(v);
         end
         6'h02: begin
            v = blank(4'd14); v.psrc = 2'b10; v.pcw = 1'b1;
            tr.push_back(v);
         end
         6'h08: begin
            v = blank(4'd11); v.a_sel = 2'b10; v.b_sel = 2'b10; v.op = 3'b001; v.aow = 1'b1;
            tr.push_back(v);
            v = blank(4'd12); v.rw = 1'b1;
            tr.push_back(v);
         end
         default: begin
            v = blank(4'd15); v.ill = 1'b1;
            tr.push_back(v);
         end
      endcase
      n = (cut > 0 && cut < tr.size()) ? cut : tr.size();
      for (int i = 0; i < n; i++) push_exp(d, tr[i]);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Compares one expected cycle against an instance and checks the invariants.
   task automatic check_output(input int d);
      vec_t want;
      vec_t got;
      if (d == 0) begin
         if (expq0.size() == 0) return;
         want = expq0.pop_front();
      end else begin
         if (expq1.size() == 0) return;
         want = expq1.pop_front();
      end
      got = obs[d];
      compared++;
      if (got !== want) begin
         failed++;
         $display("[TB] FAIL dut%0d cycle_outputs at %0t: got state=%0d bits=%h, want state=%0d bits=%h",
                  d, $time, got.st, got, want.st, want);
      end
      compared++;
      if (got.pcw === 1'b1 && got.pcwc === 1'b1) begin
         failed++;
         $display("[TB] FAIL dut%0d pc_write_exclusive: got both high, want at most one", d);
      end
      compared++;
      if (got.memwr === 1'b1 && (got.irw === 1'b1 || got.mdrw === 1'b1)) begin
         failed++;
         $display("[TB] FAIL dut%0d mem_wr_overlap: got mem_wr with ir/mdr write, want exclusive", d);
      end
      compared++;
      if (got.a_sel === 2'b01) begin
         failed++;
         $display("[TB] FAIL dut%0d ula_a_reserved: got 01, want never 01", d);
      end
   endtask

   // Monitor: samples both instances on every falling edge.
   initial begin
      forever begin
         @(negedge clk);
         check_output(0);
         check_output(1);
      end
   end

   // Runs a directed program and then a random instruction stream on one instance.
   task automatic run_program(input int d);
      int mw;
      int sel;
      logic [5:0] op;
      logic [5:0] f;
      mw = (d == 0) ? MW0 : MW1;
      @(posedge clk);
      #1;
      push_exp(d, blank(4'd0));
      reset_dut(d, 3);
      apply_stimulus(d, 6'h00, 6'h22, 0);
      apply_stimulus(d, 6'h23, 6'h00, 0);
      apply_stimulus(d, 6'h2B, 6'h00, 0);
      apply_stimulus(d, 6'h05, 6'h00, 0);
      apply_stimulus(d, 6'h04, 6'h00, 0);
      apply_stimulus(d, 6'h02, 6'h00, 0);
      apply_stimulus(d, 6'h08, 6'h00, 0);
      apply_stimulus(d, 6'h3F, 6'h00, 0);
      apply_stimulus(d, 6'h00, 6'h3F, 0);
      apply_stimulus(d, 6'h00, 6'h2A, 0);
      apply_stimulus(d, 6'h2B, 6'h00, mw + 5);
      reset_dut(d, 2);
      apply_stimulus(d, 6'h23, 6'h00, mw + 5);
      reset_dut(d, 1);
      apply_stimulus(d, 6'h23, 6'h00, 0);
      for (int k = 0; k < 40; k++) begin
         sel = $urandom_range(0, 8);
         case (sel)
            0: op = 6'h00;
            1: op = 6'h23;
            2: op = 6'h2B;
            3: op = 6'h04;
            4: op = 6'h05;
            5: op = 6'h02;
            6: op = 6'h08;
            7: op = 6'h00;
            default: op = 6'($urandom_range(0, 63));
         endcase
         case ($urandom_range(0, 5))
            0: f = 6'h20;
            1: f = 6'h22;
            2: f = 6'h24;
            3: f = 6'h25;
            4: f = 6'h2A;
            default: f = 6'($urandom_range(0, 63));
         endcase
         if ($urandom_range(0, 7) == 0) begin
            apply_stimulus(d, op, f, int'($urandom_range(1, 8)));
            reset_dut(d, int'($urandom_range(1, 2)));
         end else begin
            apply_stimulus(d, op, f, 0);
         end
      end
   endtask

   // Main sequence: both instances run concurrently, then the queues must be drained.
   initial begin
      rst[0] = 1'b1;
      rst[1] = 1'b1;
      opc[0] = 6'h00; opc[1] = 6'h00;
      fn[0]  = 6'h00; fn[1]  = 6'h00;
      fork
         run_program(0);
         run_program(1);
      join
      @(negedge clk);
      @(negedge clk);
      compared++;
      if (expq0.size() + expq1.size() != 0) begin
         failed++;
         $display("[TB] FAIL queue_drain: got %0d entries left, want 0", expq0.size() + expq1.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
